// File: rtl/fproc_arb_pkg.sv
// Shared types and default sizing for the fproc arbiter.
package fproc_arb_pkg;

  localparam int unsigned DEF_N_CORES    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ID_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fproc_arbiter_if.sv
// Request/response channel between the arbiter and the shared function processor.
interface fproc_arbiter_if
  import fproc_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH
) ();

  logic                  fp_req_valid;
  logic [ID_WIDTH-1:0]   fp_req_id;
  logic                  fp_req_ready;
  logic                  fp_resp_valid;
  logic [DATA_WIDTH-1:0] fp_resp_data;

  modport master (
    output fp_req_valid,
    output fp_req_id,
    input  fp_req_ready,
    input  fp_resp_valid,
    input  fp_resp_data
  );

  modport slave (
    input  fp_req_valid,
    input  fp_req_id,
    output fp_req_ready,
    output fp_resp_valid,
    output fp_resp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending requester at or after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             valid_c
);

  always_comb begin
    int unsigned j;
    j           = 0;
    grant_c     = '0;
    grant_idx_c = '0;
    valid_c     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!valid_c && pending[IDX_W'(j)]) begin
        valid_c                = 1'b1;
        grant_c[IDX_W'(j)]     = 1'b1;
        grant_idx_c            = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one function-processor port among N_CORES cores, one transaction at a time,
// with per-core request latching and round-robin service order.
module fproc_arbiter
  import fproc_arb_pkg::*;
#(
  parameter int unsigned N_CORES    = DEF_N_CORES,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          core_req_en,
  input  logic [N_CORES*ID_WIDTH-1:0] core_req_id,
  output logic [N_CORES-1:0]          core_ready,
  output logic [DATA_WIDTH-1:0]       core_data,
  output logic                        busy,
  output logic                        err_dup_req,
  fproc_arbiter_if.master             fp
);

  localparam int unsigned IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  arb_state_t          state;
  logic [N_CORES-1:0]  pending;
  logic [ID_WIDTH-1:0] id_q [N_CORES];
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    grant;
  logic [N_CORES-1:0]  grant_oh;
  logic                req_valid_q;
  logic [ID_WIDTH-1:0] req_id_q;

  logic [N_CORES-1:0]  rr_grant_c;
  logic [IDX_W-1:0]    rr_idx_c;
  logic                rr_valid_c;

  rr_arbiter #(
    .N     (N_CORES),
    .IDX_W (IDX_W)
  ) u_rr (
    .pending     (pending),
    .ptr         (ptr),
    .grant_c     (rr_grant_c),
    .grant_idx_c (rr_idx_c),
    .valid_c     (rr_valid_c)
  );

  assign fp.fp_req_valid = req_valid_q;
  assign fp.fp_req_id    = req_id_q;

  // Per-core request capture; a request while already pending is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending     <= '0;
      err_dup_req <= 1'b0;
      for (int unsigned k = 0; k < N_CORES; k++) begin
        id_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_CORES; k++) begin
        if (core_req_en[k] && pending[k]) begin
          err_dup_req <= 1'b1;
        end
        if (state == ST_RESP && grant_oh[k]) begin
          pending[k] <= 1'b0;
        end else if (core_req_en[k] && !pending[k]) begin
          pending[k] <= 1'b1;
          id_q[k]    <= core_req_id[k*ID_WIDTH +: ID_WIDTH];
        end
      end
    end
  end

  // Transaction sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_oh    <= '0;
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
      core_ready  <= '0;
      core_data   <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr_valid_c) begin
            grant       <= rr_idx_c;
            grant_oh    <= rr_grant_c;
            req_valid_q <= 1'b1;
            req_id_q    <= id_q[rr_idx_c];
            busy        <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (fp.fp_req_ready) begin
            req_valid_q <= 1'b0;
            req_id_q    <= '0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fp.fp_resp_valid) begin
            core_data  <= fp.fp_resp_data;
            core_ready <= grant_oh;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          core_ready <= '0;
          busy       <= 1'b0;
          ptr        <= (grant == IDX_W'(N_CORES - 1)) ? '0 : grant + IDX_W'(1);
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
